// File: rtl/sparc_pkg.sv
// Shared SPARC V8 definitions: PSR field positions, icc bit order, Bicc
// condition encodings and the default register-window count.
package sparc_pkg;

    localparam int NWINDOWS_DEFAULT = 8;

    // PSR field positions
    localparam int PSR_IMPL_LSB = 28;
    localparam int PSR_VER_LSB  = 24;
    localparam int PSR_ICC_LSB  = 20;
    localparam int PSR_EC_BIT   = 13;
    localparam int PSR_EF_BIT   = 12;
    localparam int PSR_PIL_LSB  = 8;
    localparam int PSR_S_BIT    = 7;
    localparam int PSR_PS_BIT   = 6;
    localparam int PSR_ET_BIT   = 5;
    localparam int PSR_CWP_LSB  = 0;

    // Bit order inside the 4-bit icc vector {n, z, v, c}
    localparam int ICC_N = 3;
    localparam int ICC_Z = 2;
    localparam int ICC_V = 1;
    localparam int ICC_C = 0;

    // Bicc cond field encodings
    typedef enum logic [3:0] {
        COND_BN   = 4'b0000,
        COND_BE   = 4'b0001,
        COND_BLE  = 4'b0010,
        COND_BL   = 4'b0011,
        COND_BLEU = 4'b0100,
        COND_BCS  = 4'b0101,
        COND_BNEG = 4'b0110,
        COND_BVS  = 4'b0111,
        COND_BA   = 4'b1000,
        COND_BNE  = 4'b1001,
        COND_BG   = 4'b1010,
        COND_BGE  = 4'b1011,
        COND_BGU  = 4'b1100,
        COND_BCC  = 4'b1101,
        COND_BPOS = 4'b1110,
        COND_BVC  = 4'b1111
    } bicc_cond_e;

endpackage

// File: rtl/branch_condition_evaluator.sv
// Combinational Bicc evaluation of a cond field against a stored icc.
module branch_condition_evaluator
    import sparc_pkg::*;
(
    input  logic [3:0] icc,
    input  logic [3:0] cond,
    output logic       taken
);

    logic n_s;
    logic z_s;
    logic v_s;
    logic c_s;

    assign n_s = icc[ICC_N];
    assign z_s = icc[ICC_Z];
    assign v_s = icc[ICC_V];
    assign c_s = icc[ICC_C];

    // Decode cond into the taken decision
    always_comb begin
        taken = 1'b0;
        case (bicc_cond_e'(cond))
            COND_BN:   taken = 1'b0;
            COND_BE:   taken = z_s;
            COND_BLE:  taken = z_s | (n_s ^ v_s);
            COND_BL:   taken = n_s ^ v_s;
            COND_BLEU: taken = c_s | z_s;
            COND_BCS:  taken = c_s;
            COND_BNEG: taken = n_s;
            COND_BVS:  taken = v_s;
            COND_BA:   taken = 1'b1;
            COND_BNE:  taken = ~z_s;
            COND_BG:   taken = ~(z_s | (n_s ^ v_s));
            COND_BGE:  taken = ~(n_s ^ v_s);
            COND_BGU:  taken = ~(c_s | z_s);
            COND_BCC:  taken = ~c_s;
            COND_BPOS: taken = ~n_s;
            COND_BVC:  taken = ~v_s;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/processor_status_register.sv
// SPARC V8 Processor State Register: icc capture, CWP window management
// with WIM checks, trap/RETT sequencing and Bicc evaluation.
module processor_status_register
    import sparc_pkg::*;
#(
    parameter int         NWINDOWS = NWINDOWS_DEFAULT,
    parameter logic [3:0] IMPL     = 4'h0,
    parameter logic [3:0] VER      = 4'h0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                alu_n,
    input  logic                alu_z,
    input  logic                alu_v,
    input  logic                alu_c,
    input  logic                icc_we,
    input  logic                save,
    input  logic                restore,
    input  logic                trap,
    input  logic                rett,
    input  logic                wr_psr,
    input  logic [31:0]         wr_data,
    input  logic [NWINDOWS-1:0] wim,
    input  logic [3:0]          cond,
    output logic [31:0]         psr,
    output logic                c_out,
    output logic [4:0]          cwp,
    output logic                branch_taken,
    output logic                win_overflow,
    output logic                win_underflow,
    output logic                illegal_instr,
    output logic                error_mode
);

    localparam logic [4:0]          CWP_MAX  = 5'(NWINDOWS - 1);
    localparam logic [5:0]          NWIN_W   = 6'(NWINDOWS);
    localparam logic [NWINDOWS-1:0] WIN_ONE  = {{(NWINDOWS-1){1'b0}}, 1'b1};

    // Architectural state
    logic [3:0] icc_r;
    logic       ec_r;
    logic       ef_r;
    logic [3:0] pil_r;
    logic       s_r;
    logic       ps_r;
    logic       et_r;
    logic [4:0] cwp_r;
    logic       overflow_r;
    logic       underflow_r;
    logic       illegal_r;
    logic       error_mode_r;

    // Next-state values
    logic [3:0] icc_s;
    logic       ec_s;
    logic       ef_s;
    logic [3:0] pil_s;
    logic       s_s;
    logic       ps_s;
    logic       et_s;
    logic [4:0] cwp_s;
    logic       overflow_s;
    logic       underflow_s;
    logic       illegal_s;
    logic       error_mode_s;

    // Window arithmetic helpers
    logic [4:0]          cwp_dec_s;
    logic [4:0]          cwp_inc_s;
    logic [NWINDOWS-1:0] dec_mask_s;
    logic [NWINDOWS-1:0] inc_mask_s;
    logic                wim_dec_s;
    logic                wim_inc_s;
    logic                wr_cwp_bad_s;

    // IMPL/VER and reserved fields of the written value are never stored
    logic unused_wr_bits_s;
    assign unused_wr_bits_s = ^{wr_data[31:24], wr_data[19:14]};

    assign cwp_dec_s    = (cwp_r == 5'd0) ? CWP_MAX : (cwp_r - 5'd1);
    assign cwp_inc_s    = (cwp_r == CWP_MAX) ? 5'd0 : (cwp_r + 5'd1);
    assign dec_mask_s   = WIN_ONE << cwp_dec_s;
    assign inc_mask_s   = WIN_ONE << cwp_inc_s;
    assign wim_dec_s    = |(wim & dec_mask_s);
    assign wim_inc_s    = |(wim & inc_mask_s);
    assign wr_cwp_bad_s = ({1'b0, wr_data[PSR_CWP_LSB +: 5]} >= NWIN_W);

    // Prioritised next-state: trap > wr_psr > rett > save/restore; icc_we
    // only applies when neither trap nor wr_psr is active
    always_comb begin
        icc_s        = icc_r;
        ec_s         = ec_r;
        ef_s         = ef_r;
        pil_s        = pil_r;
        s_s          = s_r;
        ps_s         = ps_r;
        et_s         = et_r;
        cwp_s        = cwp_r;
        overflow_s   = 1'b0;
        underflow_s  = 1'b0;
        illegal_s    = 1'b0;
        error_mode_s = error_mode_r;

        if (trap) begin
            if (et_r) begin
                et_s  = 1'b0;
                ps_s  = s_r;
                s_s   = 1'b1;
                cwp_s = cwp_dec_s;
            end else begin
                // Trap with traps disabled: processor enters error mode
                error_mode_s = 1'b1;
            end
        end else if (wr_psr) begin
            if (wr_cwp_bad_s) begin
                illegal_s = 1'b1;
            end else begin
                icc_s = wr_data[PSR_ICC_LSB +: 4];
                ec_s  = wr_data[PSR_EC_BIT];
                ef_s  = wr_data[PSR_EF_BIT];
                pil_s = wr_data[PSR_PIL_LSB +: 4];
                s_s   = wr_data[PSR_S_BIT];
                ps_s  = wr_data[PSR_PS_BIT];
                et_s  = wr_data[PSR_ET_BIT];
                cwp_s = wr_data[PSR_CWP_LSB +: 5];
            end
        end else begin
            if (icc_we) begin
                icc_s = {alu_n, alu_z, alu_v, alu_c};
            end else begin
                icc_s = icc_r;
            end

            if (rett) begin
                if (et_r || !s_r) begin
                    illegal_s = 1'b1;
                end else if (wim_inc_s) begin
                    underflow_s = 1'b1;
                end else begin
                    cwp_s = cwp_inc_s;
                    s_s   = ps_r;
                    et_s  = 1'b1;
                end
            end else if (save && restore) begin
                illegal_s = 1'b1;
            end else if (save) begin
                if (wim_dec_s) begin
                    overflow_s = 1'b1;
                end else begin
                    cwp_s = cwp_dec_s;
                end
            end else if (restore) begin
                if (wim_inc_s) begin
                    underflow_s = 1'b1;
                end else begin
                    cwp_s = cwp_inc_s;
                end
            end else begin
                cwp_s = cwp_r;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            icc_r        <= 4'b0000;
            ec_r         <= 1'b0;
            ef_r         <= 1'b0;
            pil_r        <= 4'b0000;
            s_r          <= 1'b1;
            ps_r         <= 1'b0;
            et_r         <= 1'b0;
            cwp_r        <= 5'd0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
            illegal_r    <= 1'b0;
            error_mode_r <= 1'b0;
        end else begin
            icc_r        <= icc_s;
            ec_r         <= ec_s;
            ef_r         <= ef_s;
            pil_r        <= pil_s;
            s_r          <= s_s;
            ps_r         <= ps_s;
            et_r         <= et_s;
            cwp_r        <= cwp_s;
            overflow_r   <= overflow_s;
            underflow_r  <= underflow_s;
            illegal_r    <= illegal_s;
            error_mode_r <= error_mode_s;
        end
    end

    assign psr = {IMPL, VER, icc_r, 6'b000000, ec_r, ef_r, pil_r,
                  s_r, ps_r, et_r, cwp_r};

    assign c_out         = icc_r[ICC_C];
    assign cwp           = cwp_r;
    assign win_overflow  = overflow_r;
    assign win_underflow = underflow_r;
    assign illegal_instr = illegal_r;
    assign error_mode    = error_mode_r;

    branch_condition_evaluator u_bcond (
        .icc   (icc_r),
        .cond  (cond),
        .taken (branch_taken)
    );

endmodule

// File: tb/tb_processor_status_register.sv
// Directed self-checking bench for processor_status_register (NWINDOWS=8).
module tb_processor_status_register;

    logic        clk;
    logic        reset_n;
    logic        alu_n, alu_z, alu_v, alu_c;
    logic        icc_we, save, restore, trap, rett, wr_psr;
    logic [31:0] wr_data;
    logic [7:0]  wim;
    logic [3:0]  cond;
    logic [31:0] psr;
    logic        c_out;
    logic [4:0]  cwp;
    logic        branch_taken, win_overflow, win_underflow, illegal_instr, error_mode;

    int tests_run = 0;
    int tests_failed = 0;

    processor_status_register #(.NWINDOWS(8), .IMPL(4'h0), .VER(4'h0)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .alu_n         (alu_n),
        .alu_z         (alu_z),
        .alu_v         (alu_v),
        .alu_c         (alu_c),
        .icc_we        (icc_we),
        .save          (save),
        .restore       (restore),
        .trap          (trap),
        .rett          (rett),
        .wr_psr        (wr_psr),
        .wr_data       (wr_data),
        .wim           (wim),
        .cond          (cond),
        .psr           (psr),
        .c_out         (c_out),
        .cwp           (cwp),
        .branch_taken  (branch_taken),
        .win_overflow  (win_overflow),
        .win_underflow (win_underflow),
        .illegal_instr (illegal_instr),
        .error_mode    (error_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ops();
        icc_we = 1'b0; save = 1'b0; restore = 1'b0;
        trap = 1'b0; rett = 1'b0; wr_psr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if (psr !== 32'h0000_0080) begin tests_failed++; $display("FAIL reset_psr: got %h expected %h", psr, 32'h0000_0080); end
        tests_run++;
        if (c_out !== 1'b0) begin tests_failed++; $display("FAIL reset_c_out: got %b expected 0", c_out); end
        tests_run++;
        if ({win_overflow, win_underflow, illegal_instr, error_mode} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_flags: got %b expected 0000", {win_overflow, win_underflow, illegal_instr, error_mode});
        end
        cond = 4'b1000; #1;
        tests_run++;
        if (branch_taken !== 1'b1) begin tests_failed++; $display("FAIL reset_ba: got %b expected 1", branch_taken); end
        cond = 4'b0000; #1;
        tests_run++;
        if (branch_taken !== 1'b0) begin tests_failed++; $display("FAIL reset_bn: got %b expected 0", branch_taken); end
        reset_n = 1'b1;
    endtask

    task automatic test_icc_capture();
        {alu_n, alu_z, alu_v, alu_c} = 4'b0001;
        icc_we = 1'b1;
        #1;
        tests_run++;
        if (c_out !== 1'b0) begin tests_failed++; $display("FAIL icc_latency: got %b expected 0", c_out); end
        tick();
        icc_we = 1'b0;
        {alu_n, alu_z, alu_v, alu_c} = 4'b1110;
        #1;
        tests_run++;
        if (c_out !== 1'b1) begin tests_failed++; $display("FAIL icc_c_out: got %b expected 1", c_out); end
        tests_run++;
        if (psr[23:20] !== 4'b0001) begin tests_failed++; $display("FAIL icc_field: got %b expected 0001", psr[23:20]); end
        cond = 4'b1101; #1;
        tests_run++;
        if (branch_taken !== 1'b0) begin tests_failed++; $display("FAIL bcc_c1: got %b expected 0", branch_taken); end
        cond = 4'b0101; #1;
        tests_run++;
        if (branch_taken !== 1'b1) begin tests_failed++; $display("FAIL bcs_c1: got %b expected 1", branch_taken); end
        // n=1,z=0,v=0,c=0: signed-compare conditions
        {alu_n, alu_z, alu_v, alu_c} = 4'b1000;
        icc_we = 1'b1;
        tick();
        icc_we = 1'b0;
        cond = 4'b0011; #1;
        tests_run++;
        if (branch_taken !== 1'b1) begin tests_failed++; $display("FAIL bl_n1: got %b expected 1", branch_taken); end
        cond = 4'b1010; #1;
        tests_run++;
        if (branch_taken !== 1'b0) begin tests_failed++; $display("FAIL bg_n1: got %b expected 0", branch_taken); end
        cond = 4'b1001; #1;
        tests_run++;
        if (branch_taken !== 1'b1) begin tests_failed++; $display("FAIL bne_z0: got %b expected 1", branch_taken); end
        cond = 4'b0100; #1;
        tests_run++;
        if (branch_taken !== 1'b0) begin tests_failed++; $display("FAIL bleu_cz0: got %b expected 0", branch_taken); end
    endtask

    task automatic test_windows();
        wim = 8'h00;
        save = 1'b1;
        tick();
        save = 1'b0;
        tests_run++;
        if (cwp !== 5'd7) begin tests_failed++; $display("FAIL save_wrap: got %0d expected 7", cwp); end
        restore = 1'b1;
        tick();
        restore = 1'b0;
        tests_run++;
        if (cwp !== 5'd0) begin tests_failed++; $display("FAIL restore_wrap: got %0d expected 0", cwp); end
        save = 1'b1;
        tick();
        wim = 8'h40;
        tick();
        save = 1'b0;
        tests_run++;
        if (win_overflow !== 1'b1 || cwp !== 5'd7) begin
            tests_failed++; $display("FAIL save_overflow: got ovf=%b cwp=%0d expected ovf=1 cwp=7", win_overflow, cwp);
        end
        tick();
        tests_run++;
        if (win_overflow !== 1'b0) begin tests_failed++; $display("FAIL overflow_pulse: got %b expected 0", win_overflow); end
        wim = 8'h01;
        restore = 1'b1;
        tick();
        restore = 1'b0;
        tests_run++;
        if (win_underflow !== 1'b1 || cwp !== 5'd7) begin
            tests_failed++; $display("FAIL restore_underflow: got unf=%b cwp=%0d expected unf=1 cwp=7", win_underflow, cwp);
        end
        wim = 8'h00;
    endtask

    task automatic test_trap_rett();
        wr_psr = 1'b1; wr_data = 32'h0000_00A2;
        tick();
        wr_psr = 1'b0;
        tests_run++;
        if (psr !== 32'h0000_00A2) begin tests_failed++; $display("FAIL wrpsr: got %h expected %h", psr, 32'h0000_00A2); end
        trap = 1'b1;
        tick();
        trap = 1'b0;
        tests_run++;
        if (psr !== 32'h0000_00C1) begin tests_failed++; $display("FAIL trap_entry: got %h expected %h", psr, 32'h0000_00C1); end
        rett = 1'b1;
        tick();
        rett = 1'b0;
        tests_run++;
        if (psr !== 32'h0000_00E2) begin tests_failed++; $display("FAIL rett: got %h expected %h", psr, 32'h0000_00E2); end
        rett = 1'b1;
        tick();
        rett = 1'b0;
        tests_run++;
        if (illegal_instr !== 1'b1 || psr !== 32'h0000_00E2) begin
            tests_failed++; $display("FAIL rett_et1: got ill=%b psr=%h expected ill=1 psr=000000e2", illegal_instr, psr);
        end
        trap = 1'b1;
        tick();
        tests_run++;
        if (psr !== 32'h0000_00C1 || error_mode !== 1'b0) begin
            tests_failed++; $display("FAIL trap2: got psr=%h err=%b expected psr=000000c1 err=0", psr, error_mode);
        end
        tick();
        trap = 1'b0;
        tests_run++;
        if (error_mode !== 1'b1 || psr !== 32'h0000_00C1) begin
            tests_failed++; $display("FAIL error_mode: got err=%b psr=%h expected err=1 psr=000000c1", error_mode, psr);
        end
        tick();
        tick();
        tests_run++;
        if (error_mode !== 1'b1) begin tests_failed++; $display("FAIL error_sticky: got %b expected 1", error_mode); end
    endtask

    task automatic test_illegal();
        wr_psr = 1'b1; wr_data = 32'h0000_0089;
        tick();
        wr_psr = 1'b0;
        tests_run++;
        if (illegal_instr !== 1'b1 || psr !== 32'h0000_00C1) begin
            tests_failed++; $display("FAIL wrpsr_bad_cwp: got ill=%b psr=%h expected ill=1 psr=000000c1", illegal_instr, psr);
        end
        save = 1'b1; restore = 1'b1;
        tick();
        save = 1'b0; restore = 1'b0;
        tests_run++;
        if (illegal_instr !== 1'b1 || cwp !== 5'd1) begin
            tests_failed++; $display("FAIL save_restore: got ill=%b cwp=%0d expected ill=1 cwp=1", illegal_instr, cwp);
        end
        tick();
        tests_run++;
        if (illegal_instr !== 1'b0) begin tests_failed++; $display("FAIL illegal_pulse: got %b expected 0", illegal_instr); end
    endtask

    task automatic test_priority_and_reset();
        {alu_n, alu_z, alu_v, alu_c} = 4'b0000;
        icc_we = 1'b1; wr_psr = 1'b1; wr_data = 32'h00F0_00A0;
        tick();
        icc_we = 1'b0; wr_psr = 1'b0;
        tests_run++;
        if (psr !== 32'h00F0_00A0) begin tests_failed++; $display("FAIL wrpsr_over_icc: got %h expected %h", psr, 32'h00F0_00A0); end
        tests_run++;
        if (error_mode !== 1'b1) begin tests_failed++; $display("FAIL error_kept: got %b expected 1", error_mode); end
        save = 1'b1; reset_n = 1'b0;
        tick();
        save = 1'b0; reset_n = 1'b1;
        tests_run++;
        if (psr !== 32'h0000_0080 || error_mode !== 1'b0 || c_out !== 1'b0) begin
            tests_failed++; $display("FAIL mid_reset: got psr=%h err=%b c=%b expected psr=00000080 err=0 c=0", psr, error_mode, c_out);
        end
    endtask

    initial begin
        clear_ops();
        reset_n = 1'b0;
        {alu_n, alu_z, alu_v, alu_c} = 4'b0000;
        wr_data = 32'h0;
        wim = 8'h00;
        cond = 4'b0000;
        test_reset();
        test_icc_capture();
        test_windows();
        test_trap_rett();
        test_illegal();
        test_priority_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
